demod_ctrl: RTL and testbench
=============================

# demod_ctrl

Run-time controller for the test-harness demodulator. Accepts pulse-width/enable configuration over a valid/ready handshake and drives the demodulator's pulse width and active-low reset. A new width is applied only while the demodulator output is low, so no pulse is ever truncated or stretched. The block also counts emitted pulses for status readback over the UART message path.

## Interface
- PW_WIDTH, 16, pulse-width field width; equals the demod-params pulse-width field size.
- CNT_WIDTH, 16, pulse counter width.
- RESET_PW, 1, pulse width driven after reset.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration word valid.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_pulse_width  in  PW_WIDTH  requested pulse width in clk cycles.
- cfg_enable  in  1  1 = demodulator running, 0 = held in reset.
- demod_out  in  1  demodulator output, observed for idle and pulse counting.
- demod_pulse_width  out  PW_WIDTH  applied pulse width.
- demod_n_reset  out  1  active-low reset to the demodulator.
- stat_req  in  1  one-cycle request for a count snapshot.
- stat_clear  in  1  clears the pulse counter.
- stat_valid  out  1  one-cycle strobe; stat_count is valid.
- stat_count  out  CNT_WIDTH  pulse-count snapshot.

## Operation
- States:
  - DISABLED: demod_n_reset=0, cfg_ready=1.
  - RUN: demod_n_reset=1, cfg_ready=1.
  - PENDING: demod_n_reset=1, cfg_ready=0.
- Shadow registers (sh_pw, sh_en) capture cfg_pulse_width and cfg_enable on each accept.
- Width clamp: cfg_pulse_width=0 is stored as 1. The demodulator computes width-1, which would underflow to all-ones.
- DISABLED + accept: demod_pulse_width <= clamped width. If en=1, go to RUN; otherwise stay.
- RUN + accept with en=0: apply immediately. demod_pulse_width is updated and the state goes to DISABLED, aborting any pulse in progress; reset makes the demodulator idle.
- RUN + accept with en=1: go to PENDING.
- PENDING:
  - Each cycle with demod_out=0: demod_pulse_width <= sh_pw, go to RUN.
  - While demod_out=1: wait with no timeout.
- Pulse counter: increments on each demod_out rising edge (0 in previous cycle, 1 now) while demod_n_reset=1. Saturates at 2^CNT_WIDTH-1.
- stat_clear with a rising edge in the same cycle: counter = 1. stat_clear alone: counter = 0.
- stat_req: stat_count <= counter value before this cycle's update, and stat_valid=1 on the next cycle only. Back-to-back requests give back-to-back strobes.
- Reset values:
  - state DISABLED, demod_n_reset=0, demod_pulse_width=RESET_PW.
  - cfg_ready=1, stat_valid=0, stat_count=0, counter=0, edge-detect register=0.
- Reset mid-PENDING discards the shadow; no apply occurs.

## Timing
- All outputs are registered except cfg_ready, which is decoded from state.
- Accept in cycle T from DISABLED: demod_pulse_width and demod_n_reset change at T+1.
- Accept in cycle T from RUN with en=1: PENDING from T+1. The apply happens in the first cycle N ≥ T+1 with demod_out=0, and the new width is visible at N+1. Minimum latency is 2 cycles.
- Applying while demod_out=0 is safe: the demodulator compares against the width only while counting, and counting starts no earlier than N+1.
- Rising edge of demod_out in cycle T: the counter value updates at T+1.
- stat_req in cycle T: stat_valid and stat_count at T+1.
- Reset has priority over every other input.

## Structure
- Pulse-width field size and the demod-params slicing macros stay in uart_msg_consts.h. cfg words are sliced upstream by the UART message decoder.
- State encodings are module-local localparams.
- One sub-module: pulse_counter (edge detect, saturating counter, clear, snapshot/strobe). Parameterised by CNT_WIDTH.

## Test plan
- Reset, then cfg (pw=5, en=1) -> demod_n_reset=1 and demod_pulse_width=5 at T+1; cfg_ready stays 1.
- RUN with pw=5; demod_out high 3 cycles; cfg (pw=9, en=1) mid-pulse -> cfg_ready=0; pw stays 5 until demod_out falls; pw=9 one cycle after the first low cycle.
- cfg (pw=0, en=1) -> demod_pulse_width=1.
- RUN with demod_out high; cfg en=0 -> demod_n_reset=0 at T+1 with no wait; state DISABLED; cfg_ready=1.
- 3 demod_out pulses, then stat_req -> stat_valid one cycle with stat_count=3. stat_clear coincident with a 4th rising edge, then stat_req -> count=1. CNT_WIDTH=2 with 5 pulses -> 3 (saturated).
- Reset asserted while PENDING -> demod_pulse_width=RESET_PW, demod_n_reset=0, counter=0 on the next cycle.

Source files
------------

// File: rtl/demod_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// demod_ctrl_pkg
//   Shared definitions for the demodulator run-time controller: default
//   parameter values and the pulse-counter update decode.
// -----------------------------------------------------------------------------
package demod_ctrl_pkg;

    localparam int DEF_PW_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_RESET_PW  = 1;

    // What the pulse counter does in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD      = 2'd0,
        CNT_INC       = 2'd1,
        CNT_LOAD_ONE  = 2'd2,
        CNT_LOAD_ZERO = 2'd3
    } cnt_op_e;

    // A clear coincident with a counted edge leaves that edge in the count,
    // so the counter restarts at one rather than zero.
    function automatic cnt_op_e decode_cnt_op(input logic clear,
                                              input logic rise,
                                              input logic at_max);
        if (clear)
            return rise ? CNT_LOAD_ONE : CNT_LOAD_ZERO;
        if (rise && !at_max)
            return CNT_INC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/demod_ctrl_if.sv
// -----------------------------------------------------------------------------
// demod_ctrl_if
//   Bundles the controller's configuration handshake, demodulator drive and
//   status readback signals.
//   master : configuration source / demodulator / status reader side
//   slave  : demod_ctrl side
//   Signals:
//     cfg_valid, cfg_ready, cfg_pulse_width, cfg_enable  - config handshake
//     demod_out                                          - demodulator output
//     demod_pulse_width, demod_n_reset                   - demodulator drive
//     stat_req, stat_clear, stat_valid, stat_count       - pulse-count status
// -----------------------------------------------------------------------------
interface demod_ctrl_if
    import demod_ctrl_pkg::*;
#(
    parameter int PW_WIDTH  = DEF_PW_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [PW_WIDTH-1:0]  cfg_pulse_width;
    logic                 cfg_enable;

    logic                 demod_out;
    logic [PW_WIDTH-1:0]  demod_pulse_width;
    logic                 demod_n_reset;

    logic                 stat_req;
    logic                 stat_clear;
    logic                 stat_valid;
    logic [CNT_WIDTH-1:0] stat_count;

    modport master (
        output cfg_valid, cfg_pulse_width, cfg_enable,
        output demod_out, stat_req, stat_clear,
        input  cfg_ready, demod_pulse_width, demod_n_reset,
        input  stat_valid, stat_count
    );

    modport slave (
        input  cfg_valid, cfg_pulse_width, cfg_enable,
        input  demod_out, stat_req, stat_clear,
        output cfg_ready, demod_pulse_width, demod_n_reset,
        output stat_valid, stat_count
    );

endinterface

// File: rtl/demod_ctrl_pulse_counter.sv
// -----------------------------------------------------------------------------
// demod_ctrl_pulse_counter
//   Counts rising edges of the demodulator output while the demodulator is
//   out of reset, saturating at all-ones, and returns snapshots on request.
//   Ports:
//     clk, reset       - clock, synchronous active-high reset
//     count_en_i       - demodulator out of reset (edges are counted)
//     demod_out_i      - demodulator output
//     stat_req_i       - one-cycle snapshot request
//     stat_clear_i     - counter clear
//     stat_valid_o     - one-cycle strobe, stat_count_o valid
//     stat_count_o     - snapshot of the count before the request cycle
// -----------------------------------------------------------------------------
module demod_ctrl_pulse_counter
    import demod_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 count_en_i,
    input  logic                 demod_out_i,
    input  logic                 stat_req_i,
    input  logic                 stat_clear_i,
    output logic                 stat_valid_o,
    output logic [CNT_WIDTH-1:0] stat_count_o
);

    logic                 prev_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] snap_q;
    logic                 valid_q;
    logic                 rise;
    cnt_op_e              op;

    // The edge detector keeps tracking while the demodulator is held in
    // reset, so a level already high at enable is not seen as a new edge.
    assign rise = demod_out_i && !prev_q && count_en_i;
    assign op   = decode_cnt_op(stat_clear_i, rise, &cnt_q);

    always_comb begin
        cnt_d = cnt_q;
        case (op)
            CNT_INC:       cnt_d = cnt_q + CNT_WIDTH'(1);
            CNT_LOAD_ONE:  cnt_d = CNT_WIDTH'(1);
            CNT_LOAD_ZERO: cnt_d = '0;
            default:       cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= demod_out_i;
            cnt_q   <= cnt_d;
            valid_q <= stat_req_i;
            // Snapshot takes the pre-update value of this cycle.
            if (stat_req_i)
                snap_q <= cnt_q;
        end
    end

    assign stat_valid_o = valid_q;
    assign stat_count_o = snap_q;

endmodule

// File: rtl/demod_ctrl.sv
// -----------------------------------------------------------------------------
// demod_ctrl
//   Run-time controller for the test-harness demodulator. Accepts pulse
//   width / enable words, drives the demodulator's width and active-low
//   reset, and only changes the width while the demodulator output is low so
//   no pulse is truncated or stretched. Disabling takes effect immediately.
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high reset (priority over all inputs)
//     bus    - demod_ctrl_if.slave: config handshake, demodulator drive,
//              pulse-count status
// -----------------------------------------------------------------------------
module demod_ctrl
    import demod_ctrl_pkg::*;
#(
    parameter int PW_WIDTH  = DEF_PW_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int RESET_PW  = DEF_RESET_PW
) (
    input  logic          clk,
    input  logic          reset,
    demod_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_PENDING  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PW_WIDTH-1:0] pw_q, pw_d;
    logic [PW_WIDTH-1:0] sh_pw_q, sh_pw_d;
    logic                sh_en_q, sh_en_d;
    logic                n_reset_q, n_reset_d;
    logic                accept;
    logic [PW_WIDTH-1:0] cfg_pw_clamped;

    assign bus.cfg_ready = (state_q != ST_PENDING);
    assign accept        = bus.cfg_valid && bus.cfg_ready;

    // The demodulator counts to width-1; zero would wrap to all-ones.
    assign cfg_pw_clamped = (bus.cfg_pulse_width == '0) ? PW_WIDTH'(1)
                                                        : bus.cfg_pulse_width;

    // NOTE: every variable gets its default before the case so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        sh_pw_d = accept ? cfg_pw_clamped : sh_pw_q;
        sh_en_d = accept ? bus.cfg_enable : sh_en_q;

        case (state_q)
            ST_DISABLED: begin
                // Demodulator is idle in reset: any width is safe to apply.
                if (accept) begin
                    pw_d    = cfg_pw_clamped;
                    state_d = bus.cfg_enable ? ST_RUN : ST_DISABLED;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!bus.cfg_enable) begin
                        // Disable aborts any pulse, so no need to wait.
                        pw_d    = cfg_pw_clamped;
                        state_d = ST_DISABLED;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                // Counting can only start the cycle after a low output.
                if (!bus.demod_out) begin
                    pw_d    = sh_pw_q;
                    state_d = sh_en_q ? ST_RUN : ST_DISABLED;
                end
            end
            default: state_d = ST_DISABLED;
        endcase
    end

    assign n_reset_d = (state_d != ST_DISABLED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DISABLED;
            pw_q      <= PW_WIDTH'(RESET_PW);
            sh_pw_q   <= PW_WIDTH'(RESET_PW);
            sh_en_q   <= 1'b0;
            n_reset_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pw_q      <= pw_d;
            sh_pw_q   <= sh_pw_d;
            sh_en_q   <= sh_en_d;
            n_reset_q <= n_reset_d;
        end
    end

    assign bus.demod_pulse_width = pw_q;
    assign bus.demod_n_reset     = n_reset_q;

    demod_ctrl_pulse_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pulse_counter (
        .clk          (clk),
        .reset        (reset),
        .count_en_i   (n_reset_q),
        .demod_out_i  (bus.demod_out),
        .stat_req_i   (bus.stat_req),
        .stat_clear_i (bus.stat_clear),
        .stat_valid_o (bus.stat_valid),
        .stat_count_o (bus.stat_count)
    );

endmodule

// File: tb/tb_demod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_demod_ctrl
//   Self-checking bench for demod_ctrl: directed scenarios followed by a
//   randomized run, all compared each cycle against a behavioural model.
//   A second instance with a 2-bit counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_demod_ctrl;

    localparam int PW_W    = 16;
    localparam int CNT_W   = 16;
    localparam int CNT_W2  = 2;
    localparam int RST_PW  = 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    demod_ctrl_if #(.PW_WIDTH(PW_W), .CNT_WIDTH(CNT_W))  bus  ();
    demod_ctrl_if #(.PW_WIDTH(PW_W), .CNT_WIDTH(CNT_W2)) bus2 ();

    demod_ctrl #(.PW_WIDTH(PW_W), .CNT_WIDTH(CNT_W), .RESET_PW(RST_PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    demod_ctrl #(.PW_WIDTH(PW_W), .CNT_WIDTH(CNT_W2), .RESET_PW(RST_PW)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: is the demodulator running, is a width change
    // waiting, which width is applied, and how many pulses were seen.
    bit m_running;
    bit m_waiting;
    int m_width;
    int m_waiting_width;
    int m_pulses;
    bit m_last_out;
    bit m_stat_valid;
    int m_stat_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_cycle(input bit v, input int pw, input bit en, input bit dout,
                               input bit req, input bit clr, input bit rst);
        bit rising;
        bit accepted;
        int want;
        if (rst) begin
            m_running = 0; m_waiting = 0; m_width = RST_PW; m_waiting_width = 0;
            m_pulses = 0; m_last_out = 0; m_stat_valid = 0; m_stat_count = 0;
            return;
        end
        rising   = dout && !m_last_out && m_running;
        accepted = v && !m_waiting;
        want     = (pw == 0) ? 1 : pw;

        m_stat_valid = req;
        if (req) m_stat_count = m_pulses;
        if (clr)         m_pulses = rising ? 1 : 0;
        else if (rising) m_pulses = (m_pulses == CNT_MAX) ? CNT_MAX : m_pulses + 1;
        m_last_out = dout;

        if (m_waiting) begin
            if (!dout) begin
                m_width   = m_waiting_width;
                m_waiting = 0;
            end
        end else if (accepted) begin
            if (!m_running || !en) begin
                m_width   = want;
                m_running = en;
            end else begin
                m_waiting       = 1;
                m_waiting_width = want;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, let one
    // rising edge pass, then compare at the next falling edge.
    task automatic step(input bit v, input int pw, input bit en, input bit dout,
                        input bit req, input bit clr, input bit rst);
        bus.cfg_valid       = v;
        bus.cfg_pulse_width = pw[PW_W-1:0];
        bus.cfg_enable      = en;
        bus.demod_out       = dout;
        bus.stat_req        = req;
        bus.stat_clear      = clr;
        reset               = rst;
        model_cycle(v, pw, en, dout, req, clr, rst);
        @(posedge clk);
        @(negedge clk);
        check("pulse_width", 32'(bus.demod_pulse_width), 32'(m_width));
        check("n_reset",     32'(bus.demod_n_reset),     32'(m_running));
        check("cfg_ready",   32'(bus.cfg_ready),         32'(!m_waiting));
        check("stat_valid",  32'(bus.stat_valid),        32'(m_stat_valid));
        check("stat_count",  32'(bus.stat_count),        32'(m_stat_count));
    endtask

    task automatic idle(input bit dout);
        step(0, 0, 0, dout, 0, 0, 0);
    endtask

    initial begin
        bit dout_r;

        bus2.cfg_valid = 0; bus2.cfg_pulse_width = '0; bus2.cfg_enable = 0;
        bus2.demod_out = 0; bus2.stat_req = 0; bus2.stat_clear = 0;
        reset = 1;
        @(negedge clk);

        // Reset state.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("rst_pw",       32'(bus.demod_pulse_width), 32'(RST_PW));
        check("rst_n_reset",  32'(bus.demod_n_reset),     0);
        check("rst_ready",    32'(bus.cfg_ready),         1);
        check("rst_svalid",   32'(bus.stat_valid),        0);

        // Enable from DISABLED: visible on the next cycle.
        step(1, 5, 1, 0, 0, 0, 0);
        check("en_pw5",       32'(bus.demod_pulse_width), 5);
        check("en_n_reset",   32'(bus.demod_n_reset),     1);
        check("en_ready",     32'(bus.cfg_ready),         1);

        // Width change mid-pulse waits for the output to fall.
        idle(1);
        idle(1);
        step(1, 9, 1, 1, 0, 0, 0);
        check("pend_ready",   32'(bus.cfg_ready),         0);
        check("pend_pw_hold", 32'(bus.demod_pulse_width), 5);
        idle(1);
        check("pend_pw_hold2", 32'(bus.demod_pulse_width), 5);
        idle(0);
        check("apply_pw9",    32'(bus.demod_pulse_width), 9);
        check("apply_ready",  32'(bus.cfg_ready),         1);

        // Zero width is clamped to one.
        step(1, 0, 1, 0, 0, 0, 0);
        idle(0);
        check("clamp_pw1",    32'(bus.demod_pulse_width), 1);

        // Disable while a pulse is high takes effect immediately.
        idle(1);
        step(1, 7, 0, 1, 0, 0, 0);
        check("dis_n_reset",  32'(bus.demod_n_reset),     0);
        check("dis_ready",    32'(bus.cfg_ready),         1);
        check("dis_pw7",      32'(bus.demod_pulse_width), 7);

        // Pulse counting and snapshot.
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            idle(0);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        check("cnt3_valid",   32'(bus.stat_valid),        1);
        check("cnt3_count",   32'(bus.stat_count),        3);
        idle(0);
        check("cnt3_strobe",  32'(bus.stat_valid),        0);
        step(0, 0, 0, 1, 0, 1, 0);
        idle(0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("clr_edge_cnt", 32'(bus.stat_count),        1);
        step(0, 0, 0, 0, 1, 0, 0);
        check("b2b_valid",    32'(bus.stat_valid),        1);

        // Reset while a width change is waiting discards it.
        idle(1);
        step(1, 20, 1, 1, 0, 0, 0);
        check("pend2_ready",  32'(bus.cfg_ready),         0);
        step(0, 0, 0, 1, 0, 0, 1);
        check("rstp_pw",      32'(bus.demod_pulse_width), 32'(RST_PW));
        check("rstp_n_reset", 32'(bus.demod_n_reset),     0);
        idle(0);
        check("rstp_no_apply", 32'(bus.demod_pulse_width), 32'(RST_PW));
        step(0, 0, 0, 0, 1, 0, 0);
        check("rstp_cnt0",    32'(bus.stat_count),        0);

        // Randomized traffic against the model.
        dout_r = 0;
        for (int i = 0; i < 600; i++) begin
            bit v, en, req, clr, rst;
            int pw;
            if ($urandom_range(0, 3) == 0) dout_r = ~dout_r;
            v   = ($urandom_range(0, 9) < 3);
            pw  = $urandom_range(0, 12);
            en  = ($urandom_range(0, 9) < 8);
            req = ($urandom_range(0, 9) < 2);
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 59) == 0);
            step(v, pw, en, dout_r, req, clr, rst);
        end
        idle(0);

        // Saturation with a 2-bit counter: five pulses read back as three.
        bus2.cfg_valid = 1; bus2.cfg_pulse_width = 16'd4; bus2.cfg_enable = 1;
        @(posedge clk); @(negedge clk);
        bus2.cfg_valid = 0;
        check("sat_n_reset", 32'(bus2.demod_n_reset), 1);
        for (int i = 0; i < 5; i++) begin
            bus2.demod_out = 1; @(posedge clk); @(negedge clk);
            bus2.demod_out = 0; @(posedge clk); @(negedge clk);
        end
        bus2.stat_req = 1; @(posedge clk); @(negedge clk);
        bus2.stat_req = 0;
        check("sat_valid",   32'(bus2.stat_valid), 1);
        check("sat_count",   32'(bus2.stat_count), 3);
        @(posedge clk); @(negedge clk);
        check("sat_strobe",  32'(bus2.stat_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
